// File: rtl/ioreg_script_pkg.sv
// Shared definitions for the ioreg script player: FSM state encoding and the
// sound-register address map (NR10..NR52 at FF10..FF26).
package ioreg_script_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RBACK,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [15:0] NR10 = 16'hFF10;
    localparam logic [15:0] NR11 = 16'hFF11;
    localparam logic [15:0] NR12 = 16'hFF12;
    localparam logic [15:0] NR13 = 16'hFF13;
    localparam logic [15:0] NR14 = 16'hFF14;
    localparam logic [15:0] NR21 = 16'hFF16;
    localparam logic [15:0] NR22 = 16'hFF17;
    localparam logic [15:0] NR23 = 16'hFF18;
    localparam logic [15:0] NR24 = 16'hFF19;
    localparam logic [15:0] NR30 = 16'hFF1A;
    localparam logic [15:0] NR31 = 16'hFF1B;
    localparam logic [15:0] NR32 = 16'hFF1C;
    localparam logic [15:0] NR33 = 16'hFF1D;
    localparam logic [15:0] NR34 = 16'hFF1E;
    localparam logic [15:0] NR41 = 16'hFF20;
    localparam logic [15:0] NR42 = 16'hFF21;
    localparam logic [15:0] NR43 = 16'hFF22;
    localparam logic [15:0] NR44 = 16'hFF23;
    localparam logic [15:0] NR50 = 16'hFF24;
    localparam logic [15:0] NR51 = 16'hFF25;
    localparam logic [15:0] NR52 = 16'hFF26;

endpackage

// File: rtl/ioreg_script_table.sv
// Script table: one synchronous write port, one asynchronous read port.
// The mask column exists only when IOREG_READBACK_EN is defined.
module ioreg_script_table #(
    parameter int NUM_ENTRIES = 8,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int DELAY_W     = 24,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [DELAY_W-1:0] wr_delay,
`ifdef IOREG_READBACK_EN
    input  logic [DATA_W-1:0]  wr_mask,
    output logic [DATA_W-1:0]  rd_mask,
`endif
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0]  rd_data,
    output logic [DELAY_W-1:0] rd_delay
);

    logic [ADDR_W-1:0]  addr_mem  [NUM_ENTRIES];
    logic [DATA_W-1:0]  data_mem  [NUM_ENTRIES];
    logic [DELAY_W-1:0] delay_mem [NUM_ENTRIES];

    // Table contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            addr_mem[wr_idx]  <= wr_addr;
            data_mem[wr_idx]  <= wr_data;
            delay_mem[wr_idx] <= wr_delay;
        end
    end

    assign rd_addr  = addr_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];
    assign rd_delay = delay_mem[rd_idx];

`ifdef IOREG_READBACK_EN
    logic [DATA_W-1:0] mask_mem [NUM_ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mask_mem[wr_idx] <= wr_mask;
        end
    end

    assign rd_mask = mask_mem[rd_idx];
`endif

endmodule

// File: rtl/ioreg_script_player.sv
// ioreg write sequencer replaying a loadable (addr, data, delay) table onto the FFxx bus.
// Optional readback compare is enabled by defining IOREG_READBACK_EN.
module ioreg_script_player
    import ioreg_script_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int DELAY_W     = 24,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic               I_CLK,
    input  logic               I_RESET_L,
    input  logic               I_LOAD_EN,
    input  logic [IDX_W-1:0]   I_LOAD_IDX,
    input  logic [ADDR_W-1:0]  I_LOAD_ADDR,
    input  logic [DATA_W-1:0]  I_LOAD_DATA,
    input  logic [DELAY_W-1:0] I_LOAD_DELAY,
    input  logic [DATA_W-1:0]  I_LOAD_MASK,
    input  logic [IDX_W:0]     I_LEN,
    input  logic               I_START,
    input  logic               I_REPEAT,
    input  logic               I_ABORT,
    input  logic [DATA_W-1:0]  I_IOREG_RDATA,
    output logic [ADDR_W-1:0]  O_IOREG_ADDR,
    output logic [DATA_W-1:0]  O_IOREG_DATA,
    output logic               O_IOREG_EN,
    output logic               O_IOREG_WE_L,
    output logic               O_IOREG_RE_L,
    output logic               O_BUSY,
    output logic               O_DONE,
    output logic [7:0]         O_LOOP_COUNT,
    output logic               O_MISMATCH,
    output logic [7:0]         O_MISMATCH_CNT
);

    localparam logic [IDX_W:0]     LEN_MAX = (IDX_W+1)'(NUM_ENTRIES);
    localparam logic [IDX_W:0]     IDX_ONE = (IDX_W+1)'(1);
    localparam logic [DELAY_W-1:0] CNT_ONE = DELAY_W'(1);

    state_t             state, next_state;
    logic [IDX_W-1:0]   idx, next_idx;
    logic [IDX_W:0]     len, len_sel;
    logic               repeat_mode;
    logic [DELAY_W-1:0] cnt;
    logic               start_go, advance, wrap, last_entry, table_we;

    logic [ADDR_W-1:0]  rd_addr;
    logic [DATA_W-1:0]  rd_data;
    logic [DELAY_W-1:0] rd_delay;

    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  data_d;
    logic               en_d, we_l_d, re_l_d, busy_d, done_d;

`ifdef IOREG_READBACK_EN
    logic [DATA_W-1:0]  rd_mask, cur_mask;
    logic               mismatch_hit;
`endif

    // Abort outranks a simultaneous start.
    assign start_go   = (state == ST_IDLE) && I_START && !I_ABORT;
    assign len_sel    = (I_LEN > LEN_MAX) ? LEN_MAX : I_LEN;
    assign last_entry = ({1'b0, idx} + IDX_ONE) >= len;
    assign table_we   = I_LOAD_EN && (state == ST_IDLE);

    ioreg_script_table #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DELAY_W     (DELAY_W),
        .IDX_W       (IDX_W)
    ) u_table (
        .clk      (I_CLK),
        .we       (table_we),
        .wr_idx   (I_LOAD_IDX),
        .wr_addr  (I_LOAD_ADDR),
        .wr_data  (I_LOAD_DATA),
        .wr_delay (I_LOAD_DELAY),
`ifdef IOREG_READBACK_EN
        .wr_mask  (I_LOAD_MASK),
        .rd_mask  (rd_mask),
`endif
        .rd_idx   (next_idx),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_delay (rd_delay)
    );

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A zero delay skips WAIT entirely, so d=0 entries are written back to back.
    always_comb begin
        next_state = state;
        next_idx   = idx;
        advance    = 1'b0;
        wrap       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_go) begin
                    next_idx   = '0;
                    next_state = (len_sel == '0) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
`ifdef IOREG_READBACK_EN
                next_state = ST_RBACK;
`else
                if (cnt == '0) advance = 1'b1;
                else           next_state = ST_WAIT;
`endif
            end
            ST_RBACK: begin
                if (cnt == '0) advance = 1'b1;
                else           next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt <= CNT_ONE) advance = 1'b1;
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase

        if (advance) begin
            if (!last_entry) begin
                next_idx   = idx + IDX_W'(1);
                next_state = ST_WRITE;
            end else if (repeat_mode) begin
                next_idx   = '0;
                wrap       = 1'b1;
                next_state = ST_WRITE;
            end else begin
                next_state = ST_DONE;
            end
        end

        if (I_ABORT && (state != ST_IDLE)) begin
            next_state = ST_IDLE;
            wrap       = 1'b0;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            idx          <= '0;
            len          <= '0;
            repeat_mode  <= 1'b0;
            cnt          <= '0;
            O_LOOP_COUNT <= '0;
        end else begin
            idx <= next_idx;
            if (start_go) begin
                len          <= len_sel;
                repeat_mode  <= I_REPEAT;
                O_LOOP_COUNT <= '0;
            end else if (wrap) begin
                O_LOOP_COUNT <= O_LOOP_COUNT + 8'd1;
            end
            if (next_state == ST_WRITE) begin
                cnt <= rd_delay;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    // Outputs are computed from the upcoming state so the registered strobes line up with it.
    always_comb begin
        addr_d = O_IOREG_ADDR;
        data_d = O_IOREG_DATA;
        en_d   = 1'b0;
        we_l_d = 1'b1;
        re_l_d = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (next_state)
            ST_WRITE: begin
                addr_d = rd_addr;
                data_d = rd_data;
                en_d   = 1'b1;
                we_l_d = 1'b0;
                busy_d = 1'b1;
            end
            ST_RBACK: begin
                re_l_d = 1'b0;
                busy_d = 1'b1;
            end
            ST_WAIT:  busy_d = 1'b1;
            ST_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            O_IOREG_ADDR <= '0;
            O_IOREG_DATA <= '0;
            O_IOREG_EN   <= 1'b0;
            O_IOREG_WE_L <= 1'b1;
            O_IOREG_RE_L <= 1'b1;
            O_BUSY       <= 1'b0;
            O_DONE       <= 1'b0;
        end else begin
            O_IOREG_ADDR <= addr_d;
            O_IOREG_DATA <= data_d;
            O_IOREG_EN   <= en_d;
            O_IOREG_WE_L <= we_l_d;
            O_IOREG_RE_L <= re_l_d;
            O_BUSY       <= busy_d;
            O_DONE       <= done_d;
        end
    end

`ifdef IOREG_READBACK_EN
    // O_IOREG_DATA still holds the written value during RBACK; the mask is latched at WRITE.
    assign mismatch_hit = (state == ST_RBACK) &&
                          (((I_IOREG_RDATA ^ O_IOREG_DATA) & cur_mask) != '0);

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            cur_mask       <= '0;
            O_MISMATCH     <= 1'b0;
            O_MISMATCH_CNT <= '0;
        end else begin
            if (next_state == ST_WRITE) begin
                cur_mask <= rd_mask;
            end
            if (start_go) begin
                O_MISMATCH     <= 1'b0;
                O_MISMATCH_CNT <= '0;
            end else if (mismatch_hit) begin
                O_MISMATCH <= 1'b1;
                if (O_MISMATCH_CNT != 8'hFF) begin
                    O_MISMATCH_CNT <= O_MISMATCH_CNT + 8'd1;
                end
            end
        end
    end
`else
    logic unused_readback;
    assign unused_readback = ^{I_LOAD_MASK, I_IOREG_RDATA};
    assign O_MISMATCH      = 1'b0;
    assign O_MISMATCH_CNT  = '0;
`endif

endmodule

// File: tb/tb_ioreg_script_player.sv
// Scoreboard bench for ioreg_script_player: expected strobes/DONE pulses are queued
// by the stimulus tasks and popped by an independent bus monitor.
`timescale 1ns/1ps
module tb_ioreg_script_player;
    import ioreg_script_pkg::*;

    localparam int NUM_ENTRIES = 8;
`ifdef IOREG_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    typedef struct {
        logic        is_done;
        logic [15:0] addr;
        logic [7:0]  data;
        int          delta;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load_en = 1'b0;
    logic [2:0]  load_idx = '0;
    logic [15:0] load_addr = '0;
    logic [7:0]  load_data = '0;
    logic [23:0] load_delay = '0;
    logic [7:0]  load_mask = '0;
    logic [3:0]  len_in = '0;
    logic        start = 1'b0;
    logic        repeat_in = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  rdata = '0;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        en, we_l, re_l, busy, done, mismatch;
    logic [7:0]  loop_count, mismatch_cnt;

    ev_t         exp_q[$];
    ev_t         mon_ev;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    logic [15:0] m_addr  [NUM_ENTRIES];
    logic [7:0]  m_data  [NUM_ENTRIES];
    int          m_delay [NUM_ENTRIES];

    ioreg_script_player dut (
        .I_CLK          (clk),
        .I_RESET_L      (rst_n),
        .I_LOAD_EN      (load_en),
        .I_LOAD_IDX     (load_idx),
        .I_LOAD_ADDR    (load_addr),
        .I_LOAD_DATA    (load_data),
        .I_LOAD_DELAY   (load_delay),
        .I_LOAD_MASK    (load_mask),
        .I_LEN          (len_in),
        .I_START        (start),
        .I_REPEAT       (repeat_in),
        .I_ABORT        (abort),
        .I_IOREG_RDATA  (rdata),
        .O_IOREG_ADDR   (addr),
        .O_IOREG_DATA   (data),
        .O_IOREG_EN     (en),
        .O_IOREG_WE_L   (we_l),
        .O_IOREG_RE_L   (re_l),
        .O_BUSY         (busy),
        .O_DONE         (done),
        .O_LOOP_COUNT   (loop_count),
        .O_MISMATCH     (mismatch),
        .O_MISMATCH_CNT (mismatch_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Bus monitor: every write strobe or DONE pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (we_l === 1'b0 || done === 1'b1)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_event: got we_l=%b done=%b addr=%h, expected no bus event", we_l, done, addr);
            end else begin
                mon_ev = exp_q.pop_front();
                check_output("event_kind", done, mon_ev.is_done);
                check_output("event_spacing", cyc - last_cyc, mon_ev.delta);
                if (!mon_ev.is_done) begin
                    check_output("write_addr", addr, mon_ev.addr);
                    check_output("write_data", data, mon_ev.data);
                    check_output("write_en", en, 1);
                end
            end
            last_cyc = cyc;
        end
    end

    function automatic void push_write(input logic [15:0] a, input logic [7:0] d, input int dl);
        exp_q.push_back('{1'b0, a, d, dl});
    endfunction

    function automatic void push_done(input int dl);
        exp_q.push_back('{1'b1, 16'h0, 8'h0, dl});
    endfunction

    task automatic load_entry(input int i, input logic [15:0] a, input logic [7:0] d,
                              input int dl, input logic [7:0] m);
        @(negedge clk);
        load_en    = 1'b1;
        load_idx   = 3'(i);
        load_addr  = a;
        load_data  = d;
        load_delay = 24'(dl);
        load_mask  = m;
        @(negedge clk);
        load_en    = 1'b0;
        m_addr[i]  = a;
        m_data[i]  = d;
        m_delay[i] = dl;
    endtask

    // Pulses START; with use_model the expected events come from the bench's table copy.
    task automatic apply_stimulus(input int len, input logic rep, input bit use_model);
        int n;
        if (use_model) begin
            n = (len > NUM_ENTRIES) ? NUM_ENTRIES : len;
            for (int i = 0; i < n; i++)
                push_write(m_addr[i], m_data[i], (i == 0) ? 1 : m_delay[i-1] + 1 + RB);
            push_done((n == 0) ? 1 : m_delay[n-1] + 1 + RB);
        end
        @(negedge clk);
        len_in    = 4'(len);
        repeat_in = rep;
        start     = 1'b1;
        last_cyc  = cyc;
        @(negedge clk);
        start     = 1'b0;
        repeat_in = 1'b0;
        check_output("busy_after_start", busy, (len == 0) ? 0 : 1);
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        repeat (3) @(negedge clk);
        check_output("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
        check_output("busy_idle", busy, 0);
    endtask

    task automatic check_reset_values();
        check_output("rst_addr", addr, 0);
        check_output("rst_data", data, 0);
        check_output("rst_en", en, 0);
        check_output("rst_we_l", we_l, 1);
        check_output("rst_re_l", re_l, 1);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_loop_count", loop_count, 0);
        check_output("rst_mismatch", mismatch, 0);
        check_output("rst_mismatch_cnt", mismatch_cnt, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;

        $display("[TB] five back-to-back writes");
        load_entry(0, NR10, 8'h11, 0, 8'h00);
        load_entry(1, NR11, 8'h80, 0, 8'h00);
        load_entry(2, NR12, 8'hF7, 0, 8'h00);
        load_entry(3, NR13, 8'hD6, 0, 8'h00);
        load_entry(4, NR14, 8'hC6, 0, 8'h00);
        load_entry(5, NR21, 8'h3F, 0, 8'h00);
        load_entry(6, NR22, 8'hF0, 0, 8'h00);
        load_entry(7, NR23, 8'h45, 0, 8'h00);
        apply_stimulus(5, 1'b0, 1'b1);
        wait_drain(100);

        $display("[TB] gap of 3 after FF12");
        load_entry(2, NR12, 8'hF7, 3, 8'h00);
        apply_stimulus(5, 1'b0, 1'b1);
        wait_drain(100);

        $display("[TB] repeat LEN=2 then abort after 7 writes");
        for (int k = 0; k < 7; k++)
            push_write((k % 2 == 0) ? NR10 : NR11, (k % 2 == 0) ? 8'h11 : 8'h80, (k == 0) ? 1 : 1 + RB);
        apply_stimulus(2, 1'b1, 1'b0);
        repeat (6 * (1 + RB)) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_output("abort_we_l", we_l, 1);
        check_output("abort_en", en, 0);
        check_output("abort_busy", busy, 0);
        check_output("abort_done", done, 0);
        check_output("abort_loop_count", loop_count, 3);
        wait_drain(20);

        $display("[TB] LEN=0 and LEN=12");
        apply_stimulus(0, 1'b0, 1'b1);
        wait_drain(20);
        apply_stimulus(12, 1'b0, 1'b1);
        wait_drain(200);

        $display("[TB] START and LOAD_EN ignored during play");
        apply_stimulus(5, 1'b0, 1'b1);
        @(negedge clk);
        start      = 1'b1;
        len_in     = 4'd1;
        load_en    = 1'b1;
        load_idx   = 3'd3;
        load_addr  = 16'hFFFF;
        load_data  = 8'hAA;
        load_delay = 24'd0;
        @(negedge clk);
        start      = 1'b0;
        load_en    = 1'b0;
        wait_drain(100);
        apply_stimulus(5, 1'b0, 1'b1);
        wait_drain(100);

        $display("[TB] asynchronous reset during WAIT");
        push_write(NR10, 8'h11, 1);
        push_write(NR11, 8'h80, 1 + RB);
        push_write(NR12, 8'hF7, 1 + RB);
        apply_stimulus(5, 1'b0, 1'b0);
        repeat (2 * (1 + RB) + 1 + RB) @(negedge clk);
        check_output("wait_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check_output("async_rst_en", en, 0);
        check_output("async_rst_we_l", we_l, 1);
        check_output("async_rst_busy", busy, 0);
        check_output("async_rst_done", done, 0);
        check_output("async_rst_addr", addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_drain(20);

`ifdef IOREG_READBACK_EN
        $display("[TB] readback compare");
        rdata = 8'h00;
        load_entry(0, NR52, 8'h80, 0, 8'h80);
        apply_stimulus(1, 1'b0, 1'b1);
        wait_drain(20);
        check_output("rb_mismatch", mismatch, 1);
        check_output("rb_mismatch_cnt", mismatch_cnt, 1);
        load_entry(0, NR52, 8'h80, 0, 8'h00);
        apply_stimulus(1, 1'b0, 1'b1);
        wait_drain(20);
        check_output("rb_masked_mismatch", mismatch, 0);
        check_output("rb_masked_cnt", mismatch_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
